// File: rtl/lsu_cluster.sv
// rtl/lsu_cluster.sv - multi-lane load/store unit, round-robin onto shared read/write channels
// Optional: LSU_LOAD_COALESCE_EN merges pending loads to the granted address into one read.
module lsu_cluster #(
    parameter int THREADS            = 4,
    parameter int DATA_MEM_ADDR_BITS = 8,
    parameter int DATA_MEM_DATA_BITS = 8
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic [THREADS-1:0]                             lane_load_enable,
    input  logic [THREADS-1:0]                             lane_store_enable,
    input  logic [THREADS-1:0][DATA_MEM_ADDR_BITS-1:0]     lane_address,
    input  logic [THREADS-1:0][DATA_MEM_DATA_BITS-1:0]     lane_store_data,
    output logic [THREADS-1:0][DATA_MEM_DATA_BITS-1:0]     lane_load_data,
    output logic [THREADS-1:0]                             lane_done,
    output logic [THREADS-1:0]                             lane_busy,
    output logic                                           data_mem_read_valid,
    output logic [DATA_MEM_ADDR_BITS-1:0]                  data_mem_read_address,
    input  logic                                           data_mem_read_ready,
    input  logic [DATA_MEM_DATA_BITS-1:0]                  data_mem_read_data,
    output logic                                           data_mem_write_valid,
    output logic [DATA_MEM_ADDR_BITS-1:0]                  data_mem_write_address,
    output logic [DATA_MEM_DATA_BITS-1:0]                  data_mem_write_data,
    input  logic                                           data_mem_write_ready
);
    localparam int LW = (THREADS > 1) ? $clog2(THREADS) : 1;

    typedef enum logic {FREE, PENDING} lane_state_t;
    typedef enum logic [1:0] {IDLE, READ, WRITE} arb_state_t;

    lane_state_t                   lane_state [THREADS];
    logic [THREADS-1:0]            lane_is_load;
    logic [DATA_MEM_ADDR_BITS-1:0] lane_addr [THREADS];
    logic [DATA_MEM_DATA_BITS-1:0] lane_data [THREADS];
    arb_state_t                    arb_state;
    logic [LW-1:0]                 rr_ptr;
    logic [LW-1:0]                 grant;
    logic [LW-1:0]                 grant_next;
    logic                          pick_found;
    logic [LW-1:0]                 pick;
    logic [LW-1:0]                 idx;
`ifdef LSU_LOAD_COALESCE_EN
    logic [THREADS-1:0]            join_mask;
`endif

    // First pending lane at or after rr_ptr, wrapping modulo THREADS.
    always_comb begin
        pick_found = 1'b0;
        pick       = '0;
        idx        = '0;
        for (int k = 0; k < THREADS; k++) begin
            idx = LW'((int'(rr_ptr) + k) % THREADS);
            if (!pick_found && lane_state[idx] == PENDING) begin
                pick_found = 1'b1;
                pick       = idx;
            end
        end
    end

    always_comb begin
        lane_busy = '0;
        for (int i = 0; i < THREADS; i++)
            lane_busy[i] = (lane_state[i] == PENDING);
    end

    assign grant_next = (grant == LW'(THREADS - 1)) ? '0 : grant + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < THREADS; i++) begin
                lane_state[i]     <= FREE;
                lane_addr[i]      <= '0;
                lane_data[i]      <= '0;
                lane_load_data[i] <= '0;
            end
            lane_is_load           <= '0;
            lane_done              <= '0;
            arb_state              <= IDLE;
            rr_ptr                 <= '0;
            grant                  <= '0;
            data_mem_read_valid    <= 1'b0;
            data_mem_read_address  <= '0;
            data_mem_write_valid   <= 1'b0;
            data_mem_write_address <= '0;
            data_mem_write_data    <= '0;
`ifdef LSU_LOAD_COALESCE_EN
            join_mask              <= '0;
`endif
        end else begin
            lane_done <= '0;
            // Capture happens only in FREE; a completing lane is PENDING here, so
            // the FREE written below on completion is not overridden.
            for (int i = 0; i < THREADS; i++) begin
                if (lane_state[i] == FREE && (lane_load_enable[i] || lane_store_enable[i])) begin
                    lane_state[i]   <= PENDING;
                    lane_is_load[i] <= lane_load_enable[i];
                    lane_addr[i]    <= lane_address[i];
                    lane_data[i]    <= lane_store_data[i];
                end
            end
            case (arb_state)
                IDLE: begin
                    if (pick_found) begin
                        grant <= pick;
                        if (lane_is_load[pick]) begin
                            data_mem_read_valid   <= 1'b1;
                            data_mem_read_address <= lane_addr[pick];
                            arb_state             <= READ;
                        end else begin
                            data_mem_write_valid   <= 1'b1;
                            data_mem_write_address <= lane_addr[pick];
                            data_mem_write_data    <= lane_data[pick];
                            arb_state              <= WRITE;
                        end
`ifdef LSU_LOAD_COALESCE_EN
                        for (int i = 0; i < THREADS; i++)
                            join_mask[i] <= (lane_state[i] == PENDING) && lane_is_load[i] &&
                                            (lane_addr[i] == lane_addr[pick]);
`endif
                    end
                end
                READ: begin
                    if (data_mem_read_ready) begin
                        data_mem_read_valid <= 1'b0;
                        rr_ptr              <= grant_next;
                        arb_state           <= IDLE;
`ifdef LSU_LOAD_COALESCE_EN
                        for (int i = 0; i < THREADS; i++) begin
                            if (join_mask[i]) begin
                                lane_load_data[i] <= data_mem_read_data;
                                lane_done[i]      <= 1'b1;
                                lane_state[i]     <= FREE;
                            end
                        end
`else
                        lane_load_data[grant] <= data_mem_read_data;
                        lane_done[grant]      <= 1'b1;
                        lane_state[grant]     <= FREE;
`endif
                    end
                end
                WRITE: begin
                    if (data_mem_write_ready) begin
                        data_mem_write_valid <= 1'b0;
                        lane_done[grant]     <= 1'b1;
                        lane_state[grant]    <= FREE;
                        rr_ptr               <= grant_next;
                        arb_state            <= IDLE;
                    end
                end
                default: arb_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_cluster.sv
// tb/tb_lsu_cluster.sv - scoreboard bench for lsu_cluster
module tb_lsu_cluster;
    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [3:0]       ld_en = '0;
    logic [3:0]       st_en = '0;
    logic [3:0][7:0]  addr = '0;
    logic [3:0][7:0]  sdata = '0;
    logic [3:0][7:0]  lane_load_data;
    logic [3:0]       lane_done;
    logic [3:0]       lane_busy;
    logic             rv, wv;
    logic [7:0]       raddr, waddr, wdata;
    logic             rd_ready = 1'b0;
    logic [7:0]       rd_data = '0;
    logic             wr_ready = 1'b0;

    typedef struct { bit is_write; logic [7:0] a; logic [7:0] d; int hold; } mem_t;
    typedef struct { logic [3:0] mask; logic [3:0][7:0] ld; } done_t;
    mem_t  mem_q[$];
    done_t done_q[$];

    int vectors = 0;
    int miscompares = 0;
    int lat = 0;
    int wcnt = 0;
    int hold_cnt = 0;
    bit stab_armed = 0;
    logic [7:0] prev_a, prev_d;
    logic [3:0][7:0] exp_ld = '0;

    lsu_cluster #(.THREADS(4), .DATA_MEM_ADDR_BITS(8), .DATA_MEM_DATA_BITS(8)) dut (
        .clk(clk), .reset(reset),
        .lane_load_enable(ld_en), .lane_store_enable(st_en),
        .lane_address(addr), .lane_store_data(sdata),
        .lane_load_data(lane_load_data), .lane_done(lane_done), .lane_busy(lane_busy),
        .data_mem_read_valid(rv), .data_mem_read_address(raddr),
        .data_mem_read_ready(rd_ready), .data_mem_read_data(rd_data),
        .data_mem_write_valid(wv), .data_mem_write_address(waddr),
        .data_mem_write_data(wdata), .data_mem_write_ready(wr_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory stub: contents are addr ^ 0xB5, ready after lat waiting cycles.
    always @(posedge clk) begin
        #1;
        if (rd_ready || wr_ready) begin
            rd_ready = 1'b0;
            wr_ready = 1'b0;
            wcnt = 0;
        end else if (rv || wv) begin
            if (wcnt >= lat) begin
                if (rv) begin
                    rd_ready = 1'b1;
                    rd_data  = raddr ^ 8'hB5;
                end else begin
                    wr_ready = 1'b1;
                end
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    // Monitor: checks every handshake and every done pulse against the queues.
    always @(negedge clk) begin
        if (!reset) begin
            if (rv && wv) chk("both_valid", 1, 0);
            if (rv || wv) hold_cnt++; else hold_cnt = 0;
            if (stab_armed && (rv || wv)) begin
                chk("addr_stable", rv ? raddr : waddr, prev_a);
                if (wv) chk("wdata_stable", wdata, prev_d);
            end
            if ((rv && rd_ready) || (wv && wr_ready)) begin
                if (mem_q.size() == 0) begin
                    chk("unexpected_mem_txn", 1, 0);
                end else begin
                    mem_t e;
                    e = mem_q.pop_front();
                    chk("txn_is_write", wv, e.is_write);
                    chk("txn_addr", rv ? raddr : waddr, e.a);
                    if (e.is_write) chk("txn_wdata", wdata, e.d);
                    if (e.hold != 0) chk("valid_hold_cycles", hold_cnt, e.hold);
                end
                hold_cnt = 0;
                stab_armed = 0;
            end else if (rv || wv) begin
                stab_armed = 1;
                prev_a = rv ? raddr : waddr;
                prev_d = wdata;
            end else begin
                stab_armed = 0;
            end
            if (lane_done != 0) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", lane_done, 0);
                end else begin
                    done_t e;
                    e = done_q.pop_front();
                    chk("done_mask", lane_done, e.mask);
                    chk("load_data", lane_load_data, e.ld);
                end
            end
        end
    end

    task automatic push_mem(input bit w, input logic [7:0] a, input logic [7:0] d, input int hold);
        mem_t e;
        e.is_write = w; e.a = a; e.d = d; e.hold = hold;
        mem_q.push_back(e);
    endtask

    task automatic push_done(input logic [3:0] mask);
        done_t e;
        e.mask = mask; e.ld = exp_ld;
        done_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk); #1;
        ld_en = '0;
        st_en = '0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #2;
            if (mem_q.size() == 0 && done_q.size() == 0 && lane_busy == 0 && !rv && !wv) begin
                ok = 1;
                break;
            end
        end
        chk("idle_timeout", ok, 1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        @(negedge clk);
        chk({tag, "_rv"}, rv, 0);
        chk({tag, "_wv"}, wv, 0);
        chk({tag, "_busy"}, lane_busy, 0);
        chk({tag, "_done"}, lane_done, 0);
        chk({tag, "_ld"}, lane_load_data, 0);
    endtask

    initial begin
        bit seen;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk_reset_state("reset");
        chk("reset_raddr", raddr, 0);
        chk("reset_waddr", waddr, 0);
        chk("reset_wdata", wdata, 0);

        // Single load, lane 2, valid held 3 cycles.
        @(posedge clk); #1;
        lat = 2;
        ld_en[2] = 1'b1; addr[2] = 8'h10;
        push_mem(0, 8'h10, 8'h00, 3);
        exp_ld[2] = 8'hA5; push_done(4'b0100);
        step(); wait_idle();

        // Store, lane 1.
        lat = 1;
        st_en[1] = 1'b1; addr[1] = 8'h20; sdata[1] = 8'h3C;
        push_mem(1, 8'h20, 8'h3C, 2);
        push_done(4'b0010);
        step(); wait_idle();

        // All four lanes load from rr_ptr=0, then wrap check.
        pulse_reset();
        exp_ld = '0;
        lat = 0;
        ld_en = 4'b1111;
        addr = {8'h03, 8'h02, 8'h01, 8'h00};
        push_mem(0, 8'h00, 8'h00, 1); push_mem(0, 8'h01, 8'h00, 1);
        push_mem(0, 8'h02, 8'h00, 1); push_mem(0, 8'h03, 8'h00, 1);
        exp_ld[0] = 8'hB5; push_done(4'b0001);
        exp_ld[1] = 8'hB4; push_done(4'b0010);
        exp_ld[2] = 8'hB7; push_done(4'b0100);
        exp_ld[3] = 8'hB6; push_done(4'b1000);
        step(); wait_idle();
        ld_en = 4'b1001; addr[3] = 8'h30; addr[0] = 8'h08;
        push_mem(0, 8'h08, 8'h00, 1); push_mem(0, 8'h30, 8'h00, 1);
        exp_ld[0] = 8'hBD; push_done(4'b0001);
        exp_ld[3] = 8'h85; push_done(4'b1000);
        step(); wait_idle();

        // Both enables: load wins; re-enable while PENDING ignored.
        lat = 3;
        ld_en[0] = 1'b1; st_en[0] = 1'b1; addr[0] = 8'h40; sdata[0] = 8'h77;
        push_mem(0, 8'h40, 8'h00, 4);
        exp_ld[0] = 8'hF5; push_done(4'b0001);
        step();
        @(posedge clk); #1;
        ld_en[0] = 1'b1; addr[0] = 8'h41;
        step();
        chk("pending_busy", lane_busy, 4'b0001);
        wait_idle();

        // Reset while a read is outstanding.
        lat = 9999;
        ld_en[1] = 1'b1; addr[1] = 8'h11;
        step();
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (rv) begin seen = 1; break; end
            @(posedge clk); #1;
        end
        chk("abort_valid_seen", seen, 1);
        pulse_reset();
        chk_reset_state("abort");
        exp_ld = '0;
        @(posedge clk); #1;
        lat = 0;
        ld_en[1] = 1'b1; addr[1] = 8'h11;
        push_mem(0, 8'h11, 8'h00, 1);
        exp_ld[1] = 8'hA4; push_done(4'b0010);
        step(); wait_idle();

        // Same-address loads from lanes 0,2,3; rr_ptr is 2 here.
        ld_en = 4'b1111;
        addr = {8'h55, 8'h55, 8'h56, 8'h55};
`ifdef LSU_LOAD_COALESCE_EN
        push_mem(0, 8'h55, 8'h00, 1); push_mem(0, 8'h56, 8'h00, 1);
        exp_ld[0] = 8'hE0; exp_ld[2] = 8'hE0; exp_ld[3] = 8'hE0; push_done(4'b1101);
        exp_ld[1] = 8'hE3; push_done(4'b0010);
`else
        push_mem(0, 8'h55, 8'h00, 1); push_mem(0, 8'h55, 8'h00, 1);
        push_mem(0, 8'h55, 8'h00, 1); push_mem(0, 8'h56, 8'h00, 1);
        exp_ld[2] = 8'hE0; push_done(4'b0100);
        exp_ld[3] = 8'hE0; push_done(4'b1000);
        exp_ld[0] = 8'hE0; push_done(4'b0001);
        exp_ld[1] = 8'hE3; push_done(4'b0010);
`endif
        step(); wait_idle();

        repeat (3) @(posedge clk);
        chk("mem_q_drained", mem_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
